fifo_skew_feeder: RTL and testbench

Single-clock read-side sequencer between the bank of per-row input FIFOs and the systolic array. On `start` it drains `length` elements from each of `array_size` FIFOs with a diagonal skew: lane i begins i cycles after lane 0. Every FIFO is read in lock-step with that skew preserved. If any lane that must read is empty, the whole feeder stalls. Each lane presents registered data plus a valid flag, with zeros on idle lanes, so the array sees correctly aligned wavefronts.

---
 rtl/fifo_skew_feeder_if.sv | 24 ++
 rtl/fifo_skew_feeder.sv | 68 ++++++
 tb/tb_fifo_skew_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_skew_feeder_if.sv
// fifo_skew_if: bus between FIFO bank, skew feeder and systolic array
interface fifo_skew_if #(
  parameter int array_size = 9,
  parameter int data_size = 8,
  parameter int len_width = 8
);
  logic start;
  logic [len_width-1:0] length;
  logic [array_size-1:0] fifo_empty;
  logic [array_size*data_size-1:0] fifo_data;
  logic [array_size-1:0] fifo_r_en;
  logic [array_size*data_size-1:0] a_out;
  logic [array_size-1:0] a_valid;
  logic busy;
  logic done;
  modport master (
    output start, length, fifo_empty, fifo_data,
    input fifo_r_en, a_out, a_valid, busy, done
  );
  modport slave (
    input start, length, fifo_empty, fifo_data,
    output fifo_r_en, a_out, a_valid, busy, done
  );
endinterface

// File: rtl/fifo_skew_feeder.sv
// fifo_skew_feeder: skewed lock-step reader from a FIFO bank into a systolic array
module fifo_skew_feeder #(
  parameter int array_size = 9,
  parameter int data_size = 8,
  parameter int len_width = 8
) (
  input logic s_clk,
  input logic clear,
  fifo_skew_if.slave bus
);
  localparam int tw = $clog2((1 << len_width) + array_size);
  localparam logic [1:0] idle = 2'd0;
  localparam logic [1:0] run = 2'd1;
  localparam logic [1:0] drain = 2'd2;
  localparam logic [1:0] fin = 2'd3;
  logic [1:0] state, nxt;
  logic [tw-1:0] t, last;
  logic [len_width-1:0] len_q;
  logic flush, stall;
  logic [array_size-1:0] active, r_en, rd_d1;
  logic [array_size*data_size-1:0] keep;
  for (genvar g = 0; g < array_size; g++) begin : g_lane
    assign active[g] = t >= tw'(g) && t < tw'(g) + tw'(len_q);
    assign keep[g*data_size +: data_size] = {data_size{rd_d1[g]}};
  end
  assign last = tw'(len_q) + tw'(array_size - 2);
  assign stall = |(active & bus.fifo_empty);
  assign r_en = (state == run && !stall) ? active : '0;
  assign bus.fifo_r_en = r_en;
  // next state: zero-length jobs skip straight to the completion pulse
  always_comb begin
    nxt = state == idle ? (bus.start ? (bus.length != '0 ? run : fin) : idle) :
          state == run ? ((!stall && t == last) ? drain : run) :
          state == drain ? (flush ? fin : drain) : idle;
  end
  // control: state, step counter (frozen on stall), drain counter and status flags
  always_ff @(posedge s_clk) begin
    if (clear) begin
      state <= idle;
      t <= '0;
      len_q <= '0;
      flush <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= nxt;
      flush <= state == drain && !flush;
      bus.busy <= nxt != idle;
      bus.done <= nxt == fin;
      if (state == idle) begin
        t <= '0;
        if (bus.start) len_q <= bus.length;
      end else if (state == run && !stall) t <= t + 1'b1;
    end
  end
  // read pipeline: FIFO data is valid the cycle after its read and is registered out then
  always_ff @(posedge s_clk) begin
    if (clear) begin
      rd_d1 <= '0;
      bus.a_valid <= '0;
      bus.a_out <= '0;
    end else begin
      rd_d1 <= r_en;
      bus.a_valid <= rd_d1;
      bus.a_out <= bus.fifo_data & keep;
    end
  end
endmodule

// File: tb/tb_fifo_skew_feeder.sv
// tb_fifo_skew_feeder: scoreboard bench with FIFO bank model and skew reference model
module tb_fifo_skew_feeder;
  localparam int n = 9;
  localparam int w = 8;
  localparam int lw = 8;
  logic s_clk = 1'b0;
  logic clear = 1'b1;
  fifo_skew_if #(.array_size(n), .data_size(w), .len_width(lw)) bus ();
  fifo_skew_feeder #(.array_size(n), .data_size(w), .len_width(lw)) dut (
    .s_clk(s_clk),
    .clear(clear),
    .bus(bus)
  );
  always #5 s_clk = ~s_clk;
  int total = 0, bad = 0, cyc = 0, ndone = 0;
  logic [w-1:0] fq[n][$];
  logic [w-1:0] eq[n][$];
  int reads[n];
  int rd_first[n];
  logic [n-1:0] force_empty = '0;
  logic [n-1:0] ren_s = '0;
  logic [n-1:0] h1 = '0, h2 = '0;
  bit m_run = 1'b0, start_issue = 1'b0, rnd_mode = 1'b0;
  int mt = 0, mlen = 0, mstalls = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO bank: pops on the read enable of the previous cycle; model step counter starts with the job
  always @(posedge s_clk) begin
    cyc++;
    if (clear) m_run = 1'b0;
    else if (start_issue) begin
      m_run = 1'b1;
      mt = 0;
      mstalls = 0;
      start_issue = 1'b0;
    end
    for (int i = 0; i < n; i++)
      if (ren_s[i]) begin
        check("read of non-empty fifo", fq[i].size() > 0, 1);
        if (fq[i].size() > 0) begin
          bus.fifo_data[i*w +: w] <= fq[i].pop_front();
          reads[i]++;
        end
      end
    #2;
    for (int i = 0; i < n; i++) bus.fifo_empty[i] = force_empty[i] || fq[i].size() == 0;
  end

  // monitor: expected read enables from the step model, output latency, scoreboard data
  always @(negedge s_clk) begin
    logic [n-1:0] act;
    logic [w-1:0] v;
    bit st;
    ren_s = bus.fifo_r_en;
    if (bus.done) ndone++;
    if (m_run) begin
      for (int i = 0; i < n; i++) act[i] = mt >= i && mt < i + mlen;
      st = |(act & bus.fifo_empty);
      check("fifo_r_en", bus.fifo_r_en, st ? 0 : act);
      if (st) mstalls++;
      else if (mt == mlen + n - 2) m_run = 1'b0;
      else mt++;
    end else if (cyc > 0) check("fifo_r_en idle", bus.fifo_r_en, 0);
    for (int i = 0; i < n; i++)
      if (bus.fifo_r_en[i] && rd_first[i] < 0) rd_first[i] = cyc;
    if (cyc > 0) begin
      check("a_valid latency", bus.a_valid, h2);
      for (int i = 0; i < n; i++) begin
        v = bus.a_out[i*w +: w];
        if (bus.a_valid[i]) begin
          check("valid with pending expect", eq[i].size() > 0, 1);
          if (eq[i].size() > 0) check($sformatf("a_out lane %0d", i), v, eq[i].pop_front());
        end else check($sformatf("idle lane %0d zero", i), v, 0);
      end
    end
    if (clear) begin
      h1 = '0;
      h2 = '0;
      for (int i = 0; i < n; i++) eq[i].delete();
    end else begin
      h2 = h1;
      h1 = bus.fifo_r_en;
    end
  end

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic prefill(input int cnt, input bit rnd);
    for (int i = 0; i < n; i++) begin
      fq[i].delete();
      for (int k = 0; k < cnt; k++) fq[i].push_back(rnd ? w'($urandom) : w'(i * 16 + k));
    end
  endtask

  task automatic launch(input int len, output int sc);
    check("busy before start", bus.busy, 0);
    bus.start = 1'b1;
    bus.length = lw'(len);
    sc = cyc;
    mlen = len;
    for (int i = 0; i < n; i++) begin
      rd_first[i] = -1;
      reads[i] = 0;
      for (int k = 0; k < len; k++) eq[i].push_back(fq[i][k]);
    end
    start_issue = len > 0;
    step();
    bus.start = 1'b0;
    check("busy after start", bus.busy, 1);
  endtask

  task automatic wait_done(input int sc, input int len, output int dc);
    int tot;
    dc = -1;
    for (int k = 0; k < 2000 && dc < 0; k++) begin
      @(negedge s_clk);
      if (bus.done) dc = cyc;
      else begin
        @(posedge s_clk);
        #1;
        if (rnd_mode) for (int i = 0; i < n; i++) force_empty[i] = $urandom_range(7) == 0;
      end
    end
    force_empty = '0;
    check("done cycle", dc, len == 0 ? sc + 1 : sc + len + n + 2 + mstalls);
    step();
    check("busy after done", bus.busy, 0);
    @(negedge s_clk);
    check("done single cycle", bus.done, 0);
    tot = 0;
    for (int i = 0; i < n; i++) begin
      tot += eq[i].size();
      check($sformatf("reads lane %0d", i), reads[i], len);
    end
    check("all outputs delivered", tot, 0);
  endtask

  initial begin
    int sc, dc, d0, n0, len;
    bus.start = 1'b0;
    bus.length = '0;
    repeat (3) step();
    @(negedge s_clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset a_valid", bus.a_valid, 0);
    check("reset a_out", bus.a_out, 0);
    check("reset fifo_r_en", bus.fifo_r_en, 0);
    step();
    clear = 1'b0;
    // unstalled transfer
    step();
    prefill(4, 1'b0);
    launch(4, sc);
    wait_done(sc, 4, dc);
    d0 = dc - sc;
    check("unstalled done latency", d0, 15);
    check("lane 0 first read", rd_first[0], sc + 1);
    check("lane 8 first read", rd_first[8], sc + 9);
    // lane 3 empty for 3 cycles while active
    step();
    prefill(4, 1'b0);
    launch(4, sc);
    repeat (4) step();
    force_empty[3] = 1'b1;
    repeat (3) step();
    force_empty[3] = 1'b0;
    check("stall cycles", mstalls, 3);
    wait_done(sc, 4, dc);
    check("stall delays done", dc - sc, d0 + 3);
    // empty lane 8 before it becomes active
    step();
    prefill(4, 1'b0);
    force_empty[8] = 1'b1;
    launch(4, sc);
    repeat (7) step();
    force_empty[8] = 1'b0;
    wait_done(sc, 4, dc);
    check("inactive empty no stall", dc - sc, d0);
    // zero length
    step();
    launch(0, sc);
    wait_done(sc, 0, dc);
    // clear in RUN cycle 5, then a normal job
    step();
    prefill(4, 1'b0);
    launch(4, sc);
    repeat (4) step();
    clear = 1'b1;
    step();
    @(negedge s_clk);
    check("clear busy", bus.busy, 0);
    check("clear done", bus.done, 0);
    check("clear a_valid", bus.a_valid, 0);
    check("clear a_out", bus.a_out, 0);
    check("clear fifo_r_en", bus.fifo_r_en, 0);
    step();
    clear = 1'b0;
    prefill(4, 1'b0);
    launch(4, sc);
    wait_done(sc, 4, dc);
    check("job after clear", dc - sc, d0);
    // start while busy is ignored
    step();
    prefill(6, 1'b0);
    launch(4, sc);
    n0 = ndone;
    repeat (2) step();
    bus.start = 1'b1;
    bus.length = lw'(2);
    step();
    bus.start = 1'b0;
    wait_done(sc, 4, dc);
    repeat (5) step();
    check("single done pulse", ndone - n0, 1);
    check("fifo leftover", fq[0].size(), 2);
    // randomized jobs with random empty flags
    rnd_mode = 1'b1;
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(1, 12);
      step();
      prefill(len, 1'b1);
      launch(len, sc);
      wait_done(sc, len, dc);
    end
    rnd_mode = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
